riscv_fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard unit for the ID stage. It serves NUM_RP read ports and forwards from EX, MEM, a long-latency completion bus, and WB. A per-register scoreboard tracks outstanding long-latency ops (mul/div, variable-latency loads). The block raises a stall on load-use and scoreboard hazards, and runs a stall watchdog.

---
 rtl/riscv_fwd_scoreboard.sv | 203 ++++++++++++++++++++
 tb/tb_riscv_fwd_scoreboard.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fwd_scoreboard
//  Brief    : ID-stage operand forwarding and hazard unit. Forwards from EX,
//             MEM, the long-latency completion bus and WB; tracks outstanding
//             long-latency destinations in a per-register scoreboard; raises
//             stall on load-use, scoreboard, WAW and full hazards; watches for
//             runaway stalls with a saturating counter and a sticky flag.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_fwd_scoreboard #(
  parameter int NUM_RP   = 2,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 8,
  parameter int STALL_TO = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  // ID source operands
  input  logic [NUM_RP*AW-1:0]         rs_idx_i,
  input  logic [NUM_RP*DW-1:0]         rs_val_reg_i,
  output logic [NUM_RP*DW-1:0]         rs_val_o,
  // EX producer
  input  logic                         ex_we_i,
  input  logic [AW-1:0]                ex_idx_i,
  input  logic [DW-1:0]                ex_val_i,
  input  logic                         ex_is_load_i,
  // MEM producer
  input  logic                         mem_we_i,
  input  logic [AW-1:0]                mem_idx_i,
  input  logic                         mem_re_i,
  input  logic [DW-1:0]                mem_addr_i,
  input  logic [DW-1:0]                mem_data_i,
  // WB producer
  input  logic                         wb_we_i,
  input  logic [AW-1:0]                wb_idx_i,
  input  logic [DW-1:0]                wb_val_i,
  // Long-latency completion bus
  input  logic                         ll_done_i,
  input  logic [AW-1:0]                ll_idx_i,
  input  logic [DW-1:0]                ll_val_i,
  // Issuing instruction
  input  logic                         id_issue_i,
  input  logic                         id_ll_i,
  input  logic [AW-1:0]                id_rd_idx_i,
  // Status
  output logic                         stall_o,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic [CNT_W-1:0]             stall_cycles_o,
  output logic                         timeout_o
);

  localparam int                c_nreg      = 2**AW;
  localparam int                c_ow        = $clog2(MAX_OUT+1);
  localparam logic [c_ow-1:0]   c_out_max   = c_ow'(MAX_OUT);
  localparam logic [c_ow-1:0]   c_out_one   = c_ow'(1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;
  localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_to_thresh = CNT_W'(STALL_TO-1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_nreg-1:0] r_pending;
  logic [c_ow-1:0]   r_outstanding;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_timeout;

  // --------------------------------------------------------------------------
  // Shared combinational terms
  // --------------------------------------------------------------------------
  logic [DW-1:0]     w_mem_val;
  logic [NUM_RP-1:0] w_lu_hit;
  logic [NUM_RP-1:0] w_sb_hit;
  logic              w_rd_completing;
  logic              w_waw;
  logic              w_full;
  logic              w_stall;
  logic              w_accept;
  logic              w_done_valid;

  // A MEM-stage load supplies its data; any other MEM op supplies its ALU result
  assign w_mem_val = mem_re_i ? mem_data_i : mem_addr_i;

  // --------------------------------------------------------------------------
  // Per read port: source match, forwarding mux and hazard detection
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    logic [AW-1:0] w_src;
    logic          w_src_nz;
    logic          w_ex_hit;
    logic          w_mem_hit;
    logic          w_ll_hit;
    logic          w_wb_hit;
    logic [DW-1:0] w_fwd;

    assign w_src     = rs_idx_i[p*AW +: AW];
    assign w_src_nz  = |w_src;
    assign w_ex_hit  = ex_we_i   & w_src_nz & (ex_idx_i  == w_src);
    assign w_mem_hit = mem_we_i  & w_src_nz & (mem_idx_i == w_src);
    assign w_ll_hit  = ll_done_i & w_src_nz & (ll_idx_i  == w_src);
    assign w_wb_hit  = wb_we_i   & w_src_nz & (wb_idx_i  == w_src);

    // Youngest producer wins; x0 always reads as zero
    always_comb begin
      w_fwd = rs_val_reg_i[p*DW +: DW];
      if (!w_src_nz) begin
        w_fwd = '0;
      end else if (w_ex_hit) begin
        w_fwd = ex_val_i;
      end else if (w_mem_hit) begin
        w_fwd = w_mem_val;
      end else if (w_ll_hit) begin
        w_fwd = ll_val_i;
      end else if (w_wb_hit) begin
        w_fwd = wb_val_i;
      end
    end

    assign rs_val_o[p*DW +: DW] = w_fwd;

    // Load data is not ready in EX; the consumer must wait one cycle
    assign w_lu_hit[p] = w_ex_hit & ex_is_load_i;
    // Pending long-latency result, unless it is being delivered right now
    assign w_sb_hit[p] = r_pending[w_src] & ~w_ll_hit;
  end

  // --------------------------------------------------------------------------
  // Issue-side hazards
  // --------------------------------------------------------------------------
  // A destination completing this cycle frees its scoreboard slot for a new writer
  assign w_rd_completing = ll_done_i & (ll_idx_i == id_rd_idx_i);
  assign w_waw           = id_ll_i & r_pending[id_rd_idx_i] & ~w_rd_completing;
  // Full is judged on the registered count only, so the counter can never exceed MAX_OUT
  assign w_full          = id_ll_i & (r_outstanding == c_out_max);

  assign w_stall = id_issue_i & ((|w_lu_hit) | (|w_sb_hit) | w_waw | w_full);
  assign stall_o = w_stall;

  // x0 destinations are never tracked
  assign w_accept     = id_issue_i & id_ll_i & ~w_stall & (|id_rd_idx_i);
  // Completions to registers not on the scoreboard are stray and ignored
  assign w_done_valid = ll_done_i & r_pending[ll_idx_i];

  // --------------------------------------------------------------------------
  // Scoreboard bits: clear on completion, then set on issue so set wins
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      if (w_done_valid) begin
        r_pending[ll_idx_i] <= 1'b0;
      end
      if (w_accept) begin
        r_pending[id_rd_idx_i] <= 1'b1;
      end
    end
  end

  // Outstanding count moves only when exactly one of issue/completion happens
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_done_valid) begin
      r_outstanding <= r_outstanding + c_out_one;
    end else if (!w_accept && w_done_valid && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - c_out_one;
    end
  end

  assign outstanding_o = r_outstanding;

  // --------------------------------------------------------------------------
  // Stall watchdog
  // --------------------------------------------------------------------------
  // Consecutive stall cycles, saturating, cleared by any non-stall cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!w_stall) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != c_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  // Sticky flag raised on the edge that takes the counter to STALL_TO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_stall && (r_stall_cnt == c_to_thresh)) begin
      r_timeout <= 1'b1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_riscv_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_fwd_scoreboard
//  Brief    : Self-checking bench for riscv_fwd_scoreboard: table of
//             forwarding vectors, directed multi-cycle sequences and a
//             randomized run against a rule-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fwd_scoreboard;

  localparam int NUM_RP   = 2;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int MAX_OUT  = 4;
  localparam int CNT_W    = 8;
  localparam int STALL_TO = 5;
  localparam int OW       = $clog2(MAX_OUT+1);
  localparam int NREG     = 2**AW;
  localparam int CNT_SAT  = 2**CNT_W - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_RP*AW-1:0] rs_idx;
  logic [NUM_RP*DW-1:0] rs_val_reg;
  logic [NUM_RP*DW-1:0] rs_val;
  logic                 ex_we, ex_is_load, mem_we, mem_re, wb_we, ll_done;
  logic [AW-1:0]        ex_idx, mem_idx, wb_idx, ll_idx, id_rd_idx;
  logic [DW-1:0]        ex_val, mem_addr, mem_data, wb_val, ll_val;
  logic                 id_issue, id_ll;
  logic                 stall;
  logic [OW-1:0]        outstanding;
  logic [CNT_W-1:0]     stall_cycles;
  logic                 timeout;

  int n_checks = 0;
  int n_errors = 0;

  riscv_fwd_scoreboard #(
    .NUM_RP(NUM_RP), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT),
    .CNT_W(CNT_W), .STALL_TO(STALL_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rs_idx_i(rs_idx), .rs_val_reg_i(rs_val_reg), .rs_val_o(rs_val),
    .ex_we_i(ex_we), .ex_idx_i(ex_idx), .ex_val_i(ex_val), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_idx_i(mem_idx), .mem_re_i(mem_re),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .wb_we_i(wb_we), .wb_idx_i(wb_idx), .wb_val_i(wb_val),
    .ll_done_i(ll_done), .ll_idx_i(ll_idx), .ll_val_i(ll_val),
    .id_issue_i(id_issue), .id_ll_i(id_ll), .id_rd_idx_i(id_rd_idx),
    .stall_o(stall), .outstanding_o(outstanding),
    .stall_cycles_o(stall_cycles), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: set of busy registers plus watchdog counters
  // --------------------------------------------------------------------------
  bit m_pend [NREG];
  int m_scnt;
  bit m_tmo;

  function automatic int m_busy_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic logic [AW-1:0] src(int p);
    return rs_idx[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] m_fwd(int p);
    logic [AW-1:0] s;
    s = src(p);
    if (s == 0)                   return '0;
    if (ex_we && ex_idx == s)     return ex_val;
    if (mem_we && mem_idx == s)   return mem_re ? mem_data : mem_addr;
    if (ll_done && ll_idx == s)   return ll_val;
    if (wb_we && wb_idx == s)     return wb_val;
    return rs_val_reg[p*DW +: DW];
  endfunction

  function automatic bit m_load_use(int p);
    logic [AW-1:0] s;
    s = src(p);
    return (s != 0) && ex_we && ex_is_load && (ex_idx == s);
  endfunction

  function automatic bit m_stall();
    bit st = 0;
    logic [AW-1:0] s;
    if (!id_issue) return 0;
    for (int p = 0; p < NUM_RP; p++) begin
      s = src(p);
      if (m_load_use(p)) st = 1;
      if (m_pend[s] && !(ll_done && ll_idx == s)) st = 1;
    end
    if (id_ll) begin
      if (m_pend[id_rd_idx] && !(ll_done && ll_idx == id_rd_idx)) st = 1;
      if (m_busy_count() == MAX_OUT) st = 1;
    end
    return st;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    m_scnt = 0;
    m_tmo  = 0;
  endtask

  task automatic model_edge();
    bit st, acc;
    st  = m_stall();
    acc = id_issue && id_ll && !st && (id_rd_idx != 0);
    if (ll_done) m_pend[ll_idx] = 0;
    if (acc)     m_pend[id_rd_idx] = 1;
    if (st) begin
      if (m_scnt < CNT_SAT) m_scnt++;
      if (m_scnt >= STALL_TO) m_tmo = 1;
    end else begin
      m_scnt = 0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_idx = '0; rs_val_reg = '0;
    ex_we = 0; ex_idx = '0; ex_val = '0; ex_is_load = 0;
    mem_we = 0; mem_idx = '0; mem_re = 0; mem_addr = '0; mem_data = '0;
    wb_we = 0; wb_idx = '0; wb_val = '0;
    ll_done = 0; ll_idx = '0; ll_val = '0;
    id_issue = 0; id_ll = 0; id_rd_idx = '0;
  endtask

  // Inputs are driven 1 time unit after a rising edge; checks follow 1 unit later
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue_ll(input logic [AW-1:0] rd);
    id_issue = 1; id_ll = 1; id_rd_idx = rd;
  endtask

  // --------------------------------------------------------------------------
  // Forwarding vector table
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic          issue;
    logic          ex_we;   logic [AW-1:0] ex_idx;  logic [DW-1:0] ex_val;  logic ex_ld;
    logic          mem_we;  logic [AW-1:0] mem_idx; logic mem_re;
    logic [DW-1:0] mem_addr; logic [DW-1:0] mem_data;
    logic          wb_we;   logic [AW-1:0] wb_idx;  logic [DW-1:0] wb_val;
    logic          ll_done; logic [AW-1:0] ll_idx;  logic [DW-1:0] ll_val;
    logic [AW-1:0] rs0;     logic [AW-1:0] rs1;
    logic [DW-1:0] reg0;    logic [DW-1:0] reg1;
    logic [DW-1:0] exp0;    logic [DW-1:0] exp1;    logic exp_stall;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // EX over MEM, MEM ALU result, MEM load data
    vecs[0]  = '{1'b1, 1'b1,5'd3,32'hAA,1'b0, 1'b1,5'd3,1'b0,32'hBB,32'hCC, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd3,5'd0, 32'h70,32'h71, 32'hAA,32'h0,  1'b0};
    vecs[1]  = '{1'b1, 1'b0,5'd3,32'hAA,1'b0, 1'b1,5'd3,1'b0,32'hBB,32'hCC, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd3,5'd0, 32'h70,32'h71, 32'hBB,32'h0,  1'b0};
    vecs[2]  = '{1'b1, 1'b0,5'd3,32'hAA,1'b0, 1'b1,5'd3,1'b1,32'hBB,32'hCC, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd3,5'd0, 32'h70,32'h71, 32'hCC,32'h0,  1'b0};
    // x0 never forwards and always reads zero
    vecs[3]  = '{1'b1, 1'b1,5'd0,32'h55,1'b0, 1'b1,5'd0,1'b0,32'h55,32'h55, 1'b1,5'd0,32'h55, 1'b1,5'd0,32'h55, 5'd0,5'd0, 32'h77,32'h77, 32'h0,32'h0,   1'b0};
    vecs[4]  = '{1'b1, 1'b0,5'd0,32'h0, 1'b0, 1'b0,5'd0,1'b0,32'h0, 32'h0,  1'b1,5'd4,32'h12, 1'b0,5'd0,32'h0,  5'd0,5'd4, 32'h77,32'h77, 32'h0,32'h12,  1'b0};
    // completion bus over WB; unmatched port reads regfile
    vecs[5]  = '{1'b1, 1'b0,5'd0,32'h0, 1'b0, 1'b0,5'd0,1'b0,32'h0, 32'h0,  1'b1,5'd6,32'h77, 1'b1,5'd6,32'h66, 5'd6,5'd5, 32'h70,32'h71, 32'h66,32'h71,  1'b0};
    // MEM over completion bus
    vecs[6]  = '{1'b1, 1'b0,5'd0,32'h0, 1'b0, 1'b1,5'd6,1'b1,32'h80,32'h88, 1'b0,5'd0,32'h0,  1'b1,5'd6,32'h66, 5'd6,5'd6, 32'h70,32'h71, 32'h88,32'h88,  1'b0};
    // EX over everything
    vecs[7]  = '{1'b1, 1'b1,5'd6,32'h11,1'b0, 1'b1,5'd6,1'b0,32'h80,32'h88, 1'b1,5'd6,32'h77, 1'b1,5'd6,32'h66, 5'd6,5'd6, 32'h70,32'h71, 32'h11,32'h11,  1'b0};
    // load-use on port1 stalls only while issuing
    vecs[8]  = '{1'b1, 1'b1,5'd7,32'h99,1'b1, 1'b0,5'd0,1'b0,32'h0, 32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd8,5'd7, 32'h70,32'h71, 32'h70,32'h0,  1'b1};
    vecs[9]  = '{1'b0, 1'b1,5'd7,32'h99,1'b1, 1'b0,5'd0,1'b0,32'h0, 32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd8,5'd7, 32'h70,32'h71, 32'h70,32'h0,  1'b0};
    // load to x0 is never a hazard
    vecs[10] = '{1'b1, 1'b1,5'd0,32'h99,1'b1, 1'b0,5'd0,1'b0,32'h0, 32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd0,5'd0, 32'h70,32'h71, 32'h0,32'h0,   1'b0};
    // producer with we low does not match
    vecs[11] = '{1'b1, 1'b0,5'd0,32'h0, 1'b0, 1'b1,5'd5,1'b0,32'h50,32'h0,  1'b0,5'd4,32'h12, 1'b0,5'd0,32'h0,  5'd5,5'd4, 32'h70,32'h71, 32'h50,32'h71,  1'b0};
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    clear_inputs();
    model_reset();
    #1;
    do_reset();

    // Reset state
    #1;
    check("reset_outstanding", 32'(outstanding), 32'd0);
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);

    // Table-driven forwarding vectors (scoreboard empty)
    for (int i = 0; i < 12; i++) begin
      tick();
      id_issue = vecs[i].issue; id_ll = 0; id_rd_idx = '0;
      ex_we = vecs[i].ex_we; ex_idx = vecs[i].ex_idx; ex_val = vecs[i].ex_val; ex_is_load = vecs[i].ex_ld;
      mem_we = vecs[i].mem_we; mem_idx = vecs[i].mem_idx; mem_re = vecs[i].mem_re;
      mem_addr = vecs[i].mem_addr; mem_data = vecs[i].mem_data;
      wb_we = vecs[i].wb_we; wb_idx = vecs[i].wb_idx; wb_val = vecs[i].wb_val;
      ll_done = vecs[i].ll_done; ll_idx = vecs[i].ll_idx; ll_val = vecs[i].ll_val;
      rs_idx = {vecs[i].rs1, vecs[i].rs0};
      rs_val_reg = {vecs[i].reg1, vecs[i].reg0};
      #1;
      if (!(vecs[i].ex_we && vecs[i].ex_ld && vecs[i].rs0 != 0 && vecs[i].ex_idx == vecs[i].rs0))
        check($sformatf("vec%0d_port0", i), rs_val[DW-1:0], vecs[i].exp0);
      if (!(vecs[i].ex_we && vecs[i].ex_ld && vecs[i].rs1 != 0 && vecs[i].ex_idx == vecs[i].rs1))
        check($sformatf("vec%0d_port1", i), rs_val[2*DW-1:DW], vecs[i].exp1);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
    end

    // Load-use then the load in MEM forwards its data
    do_reset();
    ex_we = 1; ex_idx = 5'd7; ex_is_load = 1; ex_val = 32'hDEAD;
    rs_idx = {5'd7, 5'd0}; id_issue = 1;
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    tick();
    ex_we = 0; ex_is_load = 0;
    mem_we = 1; mem_idx = 5'd7; mem_re = 1; mem_data = 32'h99; mem_addr = 32'h44;
    #1;
    check("lu_release_stall", 32'(stall), 32'd0);
    check("lu_release_val", rs_val[2*DW-1:DW], 32'h99);

    // Long-latency op to x9, read-after, completion forwarding
    do_reset();
    issue_ll(5'd9);
    #1;
    check("ll_issue_stall", 32'(stall), 32'd0);
    tick();
    id_ll = 0; id_rd_idx = '0; rs_idx = {5'd0, 5'd9};
    #1;
    check("sb_stall", 32'(stall), 32'd1);
    check("sb_outstanding", 32'(outstanding), 32'd1);
    ll_done = 1; ll_idx = 5'd9; ll_val = 32'h1234;
    #1;
    check("sb_done_stall", 32'(stall), 32'd0);
    check("sb_done_val", rs_val[DW-1:0], 32'h1234);
    tick();
    clear_inputs();
    #1;
    check("sb_after_outstanding", 32'(outstanding), 32'd0);

    // Fill to MAX_OUT, full stall, simultaneous set/clear, stray completion
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      issue_ll(AW'(k));
      tick();
    end
    clear_inputs();
    #1;
    check("full_outstanding", 32'(outstanding), 32'd4);
    issue_ll(5'd5);
    #1;
    check("full_stall", 32'(stall), 32'd1);
    ll_done = 1; ll_idx = 5'd3;
    #1;
    check("full_stall_with_done", 32'(stall), 32'd1);
    tick();
    clear_inputs();
    #1;
    check("full_done_only", 32'(outstanding), 32'd3);
    ll_done = 1; ll_idx = 5'd2; issue_ll(5'd2);
    #1;
    check("waw_relieved_stall", 32'(stall), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("setclr_outstanding", 32'(outstanding), 32'd3);
    id_issue = 1; rs_idx = {5'd0, 5'd2};
    #1;
    check("setclr_pending_x2", 32'(stall), 32'd1);
    clear_inputs();
    issue_ll(5'd4);
    #1;
    check("waw_stall", 32'(stall), 32'd1);
    clear_inputs();
    ll_done = 1; ll_idx = 5'd20;
    tick();
    clear_inputs();
    #1;
    check("stray_done_outstanding", 32'(outstanding), 32'd3);

    // Watchdog: count, sticky timeout, release, saturation, async reset
    do_reset();
    ex_we = 1; ex_idx = 5'd7; ex_is_load = 1; rs_idx = {5'd7, 5'd0}; id_issue = 1;
    #1;
    check("wd_start_cycles", 32'(stall_cycles), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("wd_cycles_%0d", k), 32'(stall_cycles), 32'(k));
      check($sformatf("wd_timeout_%0d", k), 32'(timeout), (k >= 5) ? 32'd1 : 32'd0);
    end
    ex_we = 0;
    #1;
    check("wd_release_stall", 32'(stall), 32'd0);
    tick();
    check("wd_release_cycles", 32'(stall_cycles), 32'd0);
    check("wd_sticky_timeout", 32'(timeout), 32'd1);
    ex_we = 1;
    for (int k = 0; k < 260; k++) tick();
    check("wd_saturate", 32'(stall_cycles), 32'(CNT_SAT));
    ex_we = 0; id_issue = 0;
    issue_ll(5'd9);
    tick();
    clear_inputs();
    ex_we = 1; ex_idx = 5'd7; ex_is_load = 1; rs_idx = {5'd7, 5'd0}; id_issue = 1;
    tick();
    tick();
    check("wd_pre_rst_cycles", 32'(stall_cycles), 32'd2);
    check("wd_pre_rst_outstanding", 32'(outstanding), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cycles", 32'(stall_cycles), 32'd0);
    check("async_rst_timeout", 32'(timeout), 32'd0);
    check("async_rst_outstanding", 32'(outstanding), 32'd0);
    do_reset();
    id_issue = 1; rs_idx = {5'd0, 5'd9};
    #1;
    check("async_rst_pending_clear", 32'(stall), 32'd0);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NUM_RP; p++) begin
        rs_idx[p*AW +: AW] = AW'($urandom_range(0, 7));
        rs_val_reg[p*DW +: DW] = $urandom;
      end
      ex_we = ($urandom_range(0, 1) == 1); ex_idx = AW'($urandom_range(0, 7));
      ex_val = $urandom; ex_is_load = ($urandom_range(0, 5) == 0);
      mem_we = ($urandom_range(0, 1) == 1); mem_idx = AW'($urandom_range(0, 7));
      mem_re = ($urandom_range(0, 1) == 1); mem_addr = $urandom; mem_data = $urandom;
      wb_we = ($urandom_range(0, 1) == 1); wb_idx = AW'($urandom_range(0, 7)); wb_val = $urandom;
      ll_done = ($urandom_range(0, 2) == 0); ll_idx = AW'($urandom_range(0, 7)); ll_val = $urandom;
      id_issue = ($urandom_range(0, 3) != 0); id_ll = ($urandom_range(0, 1) == 1);
      id_rd_idx = AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NUM_RP; p++)
        if (!m_load_use(p))
          check($sformatf("rand%0d_port%0d", c, p), rs_val[p*DW +: DW], m_fwd(p));
      check($sformatf("rand%0d_stall", c), 32'(stall), 32'(m_stall()));
      check($sformatf("rand%0d_outstanding", c), 32'(outstanding), 32'(m_busy_count()));
      check($sformatf("rand%0d_cycles", c), 32'(stall_cycles), 32'(m_scnt));
      check($sformatf("rand%0d_timeout", c), 32'(timeout), 32'(m_tmo));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
